// File: rtl/ycbcr2rgb.sv
// Full-range BT.601 (JPEG) YCbCr to RGB converter, 8-bit 4:4:4, 4-stage pipeline.
// Ports: clk, rst (sync high), ce; de/hsync/vsync in/out; Y, Cb, Cr in; red, green, blue out.
module ycbcr2rgb (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       de_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [7:0] Y,
    input  logic [7:0] Cb,
    input  logic [7:0] Cr,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       de_out,
    output logic       hsync_out,
    output logic       vsync_out
);

    // Q2.14 coefficients, held at product width so the
    // multiplies below are plain same-width signed ops.
    localparam int PW = 25;
    localparam int SW = 26;
    localparam int LAT = 4;

    localparam logic signed [PW-1:0] K_RCR = 25'sd22970;
    localparam logic signed [PW-1:0] K_GCB = 25'sd5638;
    localparam logic signed [PW-1:0] K_GCR = 25'sd11700;
    localparam logic signed [PW-1:0] K_BCB = 25'sd29032;

    // Half an output LSB, turning the floor shift into round-half-up.
    localparam logic signed [SW-1:0] RND = 26'sd8192;

    // S1: input capture
    logic        [7:0] y1;
    logic signed [8:0] cb1;
    logic signed [8:0] cr1;

    // S2: products and biased luma
    logic signed [SW-1:0] y_s;
    logic signed [PW-1:0] p_rcr;
    logic signed [PW-1:0] p_gcb;
    logic signed [PW-1:0] p_gcr;
    logic signed [PW-1:0] p_bcb;

    // S3: per-channel sums, still scaled by 2^14
    logic signed [SW-1:0] s_r;
    logic signed [SW-1:0] s_g;
    logic signed [SW-1:0] s_b;

    // Sync delay line, tap 0 is newest
    logic [2:0] sync_q [LAT];

    // Drop the fraction (floor) then clamp to 0..255.
    function automatic logic [7:0] sat8(
        input logic signed [SW-1:0] s
    );
        logic signed [SW-1:0] q;
        q = s >>> 14;
        if (q[SW-1])
            return 8'd0;
        else if (|q[SW-2:8])
            return 8'd255;
        else
            return q[7:0];
    endfunction

    function automatic logic signed [SW-1:0] sx(
        input logic signed [PW-1:0] p
    );
        return {p[PW-1], p};
    endfunction

    // Remove the 128 chroma offset; result spans -128..127.
    function automatic logic signed [8:0] unbias(
        input logic [7:0] c
    );
        return $signed({1'b0, c}) - 9'sd128;
    endfunction

    // S1
    always_ff @(posedge clk) begin
        if (rst) begin
            y1  <= '0;
            cb1 <= '0;
            cr1 <= '0;
        end else if (ce) begin
            y1  <= Y;
            cb1 <= unbias(Cb);
            cr1 <= unbias(Cr);
        end
    end

    // S2
    always_ff @(posedge clk) begin
        if (rst) begin
            y_s   <= '0;
            p_rcr <= '0;
            p_gcb <= '0;
            p_gcr <= '0;
            p_bcb <= '0;
        end else if (ce) begin
            y_s   <= $signed({4'b0, y1, 14'd0}) + RND;
            p_rcr <= PW'(cr1) * K_RCR;
            p_gcb <= PW'(cb1) * K_GCB;
            p_gcr <= PW'(cr1) * K_GCR;
            p_bcb <= PW'(cb1) * K_BCB;
        end
    end

    // S3: magnitudes stay inside 24 bits signed,
    // so the 26-bit sums cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r <= '0;
            s_g <= '0;
            s_b <= '0;
        end else if (ce) begin
            s_r <= y_s + sx(p_rcr);
            s_g <= y_s - sx(p_gcb) - sx(p_gcr);
            s_b <= y_s + sx(p_bcb);
        end
    end

    // S4
    always_ff @(posedge clk) begin
        if (rst) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else if (ce) begin
            red   <= sat8(s_r);
            green <= sat8(s_g);
            blue  <= sat8(s_b);
        end
    end

    // Sync delay, same gating as the data path
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++)
                sync_q[i] <= '0;
        end else if (ce) begin
            sync_q[0] <= {vsync_in, hsync_in, de_in};
            for (int i = 1; i < LAT; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    assign de_out    = sync_q[LAT-1][0];
    assign hsync_out = sync_q[LAT-1][1];
    assign vsync_out = sync_q[LAT-1][2];

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Self-checking bench for ycbcr2rgb: reference model plus directed literals.
// Random and directed stimulus with ce gating and resets.
module tb_ycbcr2rgb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       de_in = 1'b0;
    logic       hsync_in = 1'b0;
    logic       vsync_in = 1'b0;
    logic [7:0] y_in = '0;
    logic [7:0] cb_in = '0;
    logic [7:0] cr_in = '0;
    logic [7:0] red, green, blue;
    logic       de_out, hsync_out, vsync_out;

    ycbcr2rgb dut (
        .clk(clk), .rst(rst), .ce(ce),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .Y(y_in), .Cb(cb_in), .Cr(cr_in),
        .red(red), .green(green), .blue(blue),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       de;
        logic       hs;
        logic       vs;
    } pix_t;

    int errors = 0;
    int checks = 0;
    pix_t q[$];
    pix_t exp_o = '0;
    bit armed = 0;

    function automatic logic [7:0] clamp(input int v);
        if (v < 0) return 8'd0;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    // Straight from the conversion equations in real-number
    // form scaled by 16384; truncation vs floor only differs
    // for negative values, which clamp to 0 either way.
    function automatic pix_t ref_px(input int yy, input int cbv,
        input int crv, input logic d, input logic h, input logic v);
        pix_t p;
        int cbs, crs, base;
        cbs = cbv - 128;
        crs = crv - 128;
        base = yy * 16384 + 8192;
        p.r = clamp((base + 22970 * crs) / 16384);
        p.g = clamp((base - 5638 * cbs - 11700 * crs) / 16384);
        p.b = clamp((base + 29032 * cbs) / 16384);
        p.de = d;
        p.hs = h;
        p.vs = v;
        return p;
    endfunction

    // Model: output is the pixel accepted 4 enabled edges ago,
    // zero until 4 pixels have been accepted since reset.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            exp_o = '0;
            armed = 1;
        end else if (ce) begin
            q.push_back(ref_px(int'(y_in), int'(cb_in), int'(cr_in),
                               de_in, hsync_in, vsync_in));
            if (q.size() > 4) void'(q.pop_front());
            if (q.size() == 4) exp_o = q[0];
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if ({red, green, blue, de_out, hsync_out, vsync_out} !== exp_o) begin
                errors++;
                $display("FAIL stream t=%0t got rgb=%0d/%0d/%0d sync=%b%b%b exp rgb=%0d/%0d/%0d sync=%b%b%b",
                         $time, red, green, blue, de_out, hsync_out, vsync_out,
                         exp_o.r, exp_o.g, exp_o.b, exp_o.de, exp_o.hs, exp_o.vs);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rgb_of(input pix_t p);
        return {8'h0, p.r, p.g, p.b};
    endfunction

    function automatic logic [31:0] dut_rgb();
        return {8'h0, red, green, blue};
    endfunction

    function automatic logic [31:0] dut_all();
        return {26'h0, red == 0, green == 0, blue == 0,
                de_out, hsync_out, vsync_out};
    endfunction

    task automatic set_px(input int yy, input int cbv, input int crv);
        y_in = 8'(yy);
        cb_in = 8'(cbv);
        cr_in = 8'(crv);
    endtask

    // Hold one pixel for 4 enabled edges, then check the output.
    task automatic lit(input string nm, input int yy, input int cbv,
        input int crv, input int er, input int eg, input int eb);
        set_px(yy, cbv, crv);
        ce = 1'b1;
        repeat (4) @(negedge clk);
        chk(nm, dut_rgb(), {8'h0, 8'(er), 8'(eg), 8'(eb)});
    endtask

    function automatic bit de_pat(input int i);
        return i >= 0 && i < 10;
    endfunction

    function automatic bit hs_pat(input int i);
        return i >= 3 && i < 7;
    endfunction

    initial begin
        int tries;
        // Power-up reset with ce low: reset must still win
        repeat (3) @(negedge clk);
        chk("reset_state", dut_all(), 32'h38);

        // Pin the model itself against hand-worked values
        chk("model_grey", rgb_of(ref_px(128, 128, 128, 0, 0, 0)), 32'h808080);
        chk("model_red", rgb_of(ref_px(76, 85, 255, 0, 0, 0)), 32'hFE0000);
        chk("model_rclamp", rgb_of(ref_px(255, 128, 255, 0, 0, 0)), 32'hFFA4FF);
        chk("model_bclamp", rgb_of(ref_px(0, 0, 128, 0, 0, 0)), 32'h002C00);

        rst = 1'b0;
        lit("grey128", 128, 128, 128, 128, 128, 128);
        lit("grey255", 255, 128, 128, 255, 255, 255);
        lit("grey0", 0, 128, 128, 0, 0, 0);
        lit("sat_red", 76, 85, 255, 254, 0, 0);
        lit("r_clamp_hi", 255, 128, 255, 255, 164, 255);
        lit("b_clamp_lo", 0, 0, 128, 0, 44, 0);

        // Sync alignment: 10-pixel de pulse, hsync from pixel 3
        ce = 1'b1;
        for (int i = 0; i < 18; i++) begin
            set_px($urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255));
            de_in = de_pat(i);
            hsync_in = hs_pat(i);
            @(negedge clk);
            if (i >= 3) begin
                chk("sync_de", {31'h0, de_out}, {31'h0, de_pat(i - 3)});
                chk("sync_hs", {31'h0, hsync_out}, {31'h0, hs_pat(i - 3)});
            end
        end
        de_in = 1'b0;
        hsync_in = 1'b0;

        // ce-gated ramp, each value consumed by exactly one enabled edge
        for (int k = 0; k < 64; k++) begin
            set_px(k, 128, 128);
            tries = 0;
            do begin
                ce = (tries >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
                tries++;
                @(negedge clk);
            end while (!ce);
        end
        ce = 1'b1;
        repeat (3) @(negedge clk);
        chk("ramp_end", dut_rgb(), 32'h3F3F3F);

        // Mid-stream reset
        for (int k = 0; k < 6; k++) begin
            set_px(100 + k, 128, 128);
            de_in = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_clear", dut_all(), 32'h38);
        rst = 1'b0;
        de_in = 1'b0;
        set_px(200, 128, 128);
        repeat (3) @(negedge clk);
        chk("post_rst_gap", dut_rgb(), 32'h0);
        @(negedge clk);
        chk("post_rst_first", dut_rgb(), 32'hC8C8C8);

        // Reset while ce is low
        de_in = 1'b1;
        vsync_in = 1'b1;
        set_px(255, 128, 255);
        repeat (5) @(negedge clk);
        ce = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ce0_clear", dut_all(), 32'h38);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ce0_hold", dut_all(), 32'h38);

        // Random traffic with random ce and occasional reset
        for (int n = 0; n < 3000; n++) begin
            set_px($urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 255));
            de_in = 1'($urandom_range(0, 1));
            hsync_in = 1'($urandom_range(0, 1));
            vsync_in = 1'($urandom_range(0, 1));
            ce = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        ce = 1'b1;
        repeat (6) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ycbcr2rgb.md
# ycbcr2rgb

Pipelined full-range BT.601 (JPEG) YCbCr-to-RGB converter for 8-bit 4:4:4 video. It is the inverse of the RGB-to-YCbCr front end and sits on the output side of the skin-detection pipeline, ahead of the display/HDMI encoder. It carries de/hsync/vsync through a matched delay so that sync stays aligned with pixel data. All arithmetic is fabric logic, with no IP cores: constant multiplies, signed sums, rounding and saturation.

## Interface
Parameters:
- None. Coefficients, latency (4) and widths are fixed localparams.

Ports:
- clk  in  1  pixel clock; all registers on rising edge
- rst  in  1  synchronous, active-high reset; overrides ce
- ce  in  1  clock enable; when low, every pipeline register holds
- de_in  in  1  data enable, aligned with Y/Cb/Cr
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- Y  in  8  luma, unsigned 0..255
- Cb  in  8  blue-difference chroma, offset 128
- Cr  in  8  red-difference chroma, offset 128
- red  out  8  unsigned, saturated 0..255
- green  out  8  unsigned, saturated 0..255
- blue  out  8  unsigned, saturated 0..255
- de_out  out  1  de_in delayed by 4 enabled cycles
- hsync_out  out  1  hsync_in delayed by 4 enabled cycles
- vsync_out  out  1  vsync_in delayed by 4 enabled cycles

## Operation
Coefficients are Q2.14 unsigned (scale 16384):
- K_RCR = 22970 (1.402)
- K_GCB = 5638 (0.344136)
- K_GCR = 11700 (0.714136)
- K_BCB = 29032 (1.772)

Equations:
- R = Y + K_RCR·cr
- G = Y − K_GCB·cb − K_GCR·cr
- B = Y + K_BCB·cb
- where cb = Cb−128 and cr = Cr−128, each 9-bit signed (−128..127).

Pipeline (each stage advances only when ce=1):
- S1: register Y (zero-extended) plus cb and cr.
- S2: four signed products, 9b × 16b, each 25-bit signed. Register y_s = (Y<<14) + 8192 (round-half-up constant).
- S3: three 26-bit signed sums: sR = y_s + pRCR; sG = y_s − pGCB − pGCR; sB = y_s + pBCB.
- S4: arithmetic shift right by 14 (floor). If the result is < 0, output 0; if > 255, output 255; otherwise output the low 8 bits. Register into red/green/blue.

Other rules:
- Worst-case sums fit in 24 bits signed (max ≈ 7.1e6, min ≈ −3.7e6). The 26-bit width gives margin, so intermediate overflow is impossible.
- de/hsync/vsync go through a 3-bit, 4-deep shift register that has the same ce gating and the same reset.
- Pixel data is converted regardless of de. Blanking values pass through the converter, and downstream logic qualifies them with de_out.

## Timing
- Latency is exactly 4 enabled clk edges from input sample to output, for both data and sync.
- Throughput is 1 pixel per enabled cycle. There is no backpressure or handshake beyond ce.
- Reset: while rst=1 at a clock edge, all S1–S4 registers and all sync delay taps clear to 0. This gives red=green=blue=0 and de_out=hsync_out=vsync_out=0 from the edge after rst is sampled high.
- Reset mid-stream: pixels in flight are discarded, not flushed. After rst drops, outputs stay 0 until the first pixel sampled after reset has traversed 4 enabled edges.
- ce=0: outputs and all internal state are frozen. Stall cycles insert no bubbles and duplicate no data.
- rst and ce=0 together: reset wins.
- No combinational path from any input to any output.

## Test plan
- Neutral grey: Y/Cb/Cr = 128/128/128, then 255/128/128, then 0/128/128 → RGB 128/128/128, then 255/255/255, then 0/0/0, exactly 4 cycles after each input.
- Saturated red: Y/Cb/Cr = 76/85/255 → R/G/B = 254/0/0. Then 255/128/255 → 255/164/255 (R clamps at the top).
- Negative clamp: Y/Cb/Cr = 0/0/128 → R/G/B = 0/44/0 (B clamps at the bottom).
- Sync alignment: a 10-pixel de pulse with an hsync edge on pixel 3, all with ce=1 → de_out and hsync_out reproduce the same pattern shifted by exactly 4 cycles, with RGB aligned to it.
- ce gating: ramp Y 0..63 with Cb=Cr=128 while toggling ce pseudo-randomly → the output sequence is the ramp 0..63 with no gaps or repeats, and values change only on edges where ce=1.
- Reset mid-stream: assert rst for 1 cycle during the ramp → all outputs are 0 on the next cycle. The first post-reset pixel appears exactly 4 enabled edges later. Assert rst with ce=0 and check that reset still clears everything.
